// File: rtl/spi_flash_id_seq.sv
// spi_flash_id_seq: command/readback sequencer in front of an SPI master core.
// Define SPI_ID_CHECK_EN to build the captured-ID comparator (drives id_match).
module spi_flash_id_seq #(
  parameter int                              DATA_W       = 16,
  parameter int                              FRAME_NUM    = 3,
  parameter logic [DATA_W-1:0]               CMD_WORD     = 16'h9000,
  parameter logic [DATA_W-1:0]               DUMMY_WORD   = '0,
  parameter logic [1:0]                      MODE         = 2'd3,
  parameter int                              POWERUP_WAIT = 100,
  parameter int                              REPEAT_WAIT  = 1000,
  parameter bit                              AUTO_REPEAT  = 1'b1,
  parameter logic [DATA_W*(FRAME_NUM-1)-1:0] EXPECT_ID    = '0
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              start,
  input  logic                              spi_done,
  input  logic [DATA_W-1:0]                 spi_rdata,
  output logic [1:0]                        spi_mode,
  output logic                              spi_en,
  output logic [DATA_W-1:0]                 spi_sdata,
  output logic                              busy,
  output logic                              id_valid,
  output logic [DATA_W*(FRAME_NUM-1)-1:0]   id_data,
  output logic                              id_match
);

  // state | meaning
  // PWR   | post-reset settling wait
  // IDLE  | ready; launches a transaction (auto or on start)
  // XFER  | spi_en high, frames in flight
  // GAP   | spi_en low, busy held until the repeat wait expires

  localparam int ID_W       = DATA_W * (FRAME_NUM - 1);
  localparam int SH_W       = (ID_W > DATA_W) ? ID_W - DATA_W : 1;
  localparam int FCNT_W     = $clog2(FRAME_NUM);
  localparam int LAST_FRAME = FRAME_NUM - 1;
  localparam int CNT_MAX    = (POWERUP_WAIT > REPEAT_WAIT) ? POWERUP_WAIT : REPEAT_WAIT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // In free-running mode the IDLE cycle is part of the wait, so the power-up
  // and repeat intervals seen on spi_en come out exact.
  localparam int PWR_TC = (AUTO_REPEAT && POWERUP_WAIT > 1) ? POWERUP_WAIT - 2 : POWERUP_WAIT - 1;
  localparam int GAP_TC = (REPEAT_WAIT >= 2) ? REPEAT_WAIT - 2 : 0;

  typedef enum logic [1:0] {ST_PWR, ST_IDLE, ST_XFER, ST_GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FCNT_W-1:0]   frame_q, frame_d;
  logic [SH_W-1:0]     shadow_q, shadow_d;
  logic [ID_W-1:0]     shadow_shift;
  logic                en_d, busy_d, valid_d;
  logic [DATA_W-1:0]   sdata_d;
  logic [ID_W-1:0]     id_d;

  assign spi_mode = MODE;

  if (ID_W > DATA_W) begin : g_shift_wide
    assign shadow_shift = {shadow_q, spi_rdata};
  end else begin : g_shift_single
    assign shadow_shift = spi_rdata;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_PWR;
      cnt_q     <= '0;
      frame_q   <= '0;
      shadow_q  <= '0;
      spi_en    <= 1'b0;
      spi_sdata <= '0;
      busy      <= 1'b0;
      id_valid  <= 1'b0;
      id_data   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      shadow_q  <= shadow_d;
      spi_en    <= en_d;
      spi_sdata <= sdata_d;
      busy      <= busy_d;
      id_valid  <= valid_d;
      id_data   <= id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    en_d     = spi_en;
    sdata_d  = spi_sdata;
    busy_d   = busy;
    valid_d  = 1'b0;
    id_d     = id_data;

    case (state_q)
      ST_PWR: begin
        if (cnt_q == CNT_W'(PWR_TC)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        if (AUTO_REPEAT || start) begin
          state_d = ST_XFER;
          en_d    = 1'b1;
          sdata_d = CMD_WORD;
          frame_d = '0;
          busy_d  = 1'b1;
        end
      end

      ST_XFER: begin
        if (spi_done) begin
          if (frame_q != '0) begin
            shadow_d = shadow_shift[SH_W-1:0];
          end
          if (frame_q == FCNT_W'(LAST_FRAME)) begin
            en_d    = 1'b0;
            sdata_d = '0;
            id_d    = shadow_shift;
            valid_d = 1'b1;
            cnt_d   = '0;
            if (AUTO_REPEAT && REPEAT_WAIT <= 1) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            frame_d = frame_q + FCNT_W'(1);
            sdata_d = DUMMY_WORD;
          end
        end
      end

      ST_GAP: begin
        if (!AUTO_REPEAT || cnt_q == CNT_W'(GAP_TC)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_PWR;
    endcase
  end

`ifdef SPI_ID_CHECK_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      id_match <= 1'b0;
    end else if (valid_d) begin
      id_match <= (shadow_shift == EXPECT_ID);
    end
  end
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT_ID;
  assign id_match      = 1'b0;
`endif

endmodule
